// File: rtl/crc5_check.sv
// Receive-side USB token CRC5 checker: assembles PID + addr/endp from the
// de-stuffed bit stream, checks the CRC5 residual, PID complement and length.
module crc5_check #(
  parameter int unsigned PKT_LEN  = 19,
  parameter int unsigned PID_LEN  = 8,
  parameter int unsigned CRC_LEN  = 5,
  parameter logic [4:0]  RESIDUAL = 5'b01100
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               pkt_start,
  input  logic               in_bit,
  input  logic               in_valid,
  input  logic               pkt_end,
  output logic [PKT_LEN-1:0] pkt_out,
  output logic [CRC_LEN-1:0] crc_rcvd,
  output logic               pkt_valid,
  output logic               crc_ok,
  output logic               crc_error,
  output logic               pid_error,
  output logic               len_error,
  output logic               busy
);

  localparam int unsigned TOTAL_LEN = PKT_LEN + CRC_LEN;
  localparam int unsigned PKT_IDX_W = $clog2(PKT_LEN);
  localparam int unsigned CRC_IDX_W = $clog2(CRC_LEN);
  localparam int unsigned PID_HALF  = PID_LEN / 2;

  typedef enum logic [2:0] {
    IDLE,
    RECV_PID,
    RECV_DATA,
    RECV_CRC,
    WAIT_EOP,
    OVERRUN,
    DONE
  } state_t;

  state_t               state;
  logic [4:0]           lfsr;
  logic [31:0]          cnt;

  logic                 recv;
  logic                 accept;
  logic                 end_now;
  logic                 fb;
  logic [PKT_IDX_W-1:0] pkt_idx;
  logic [CRC_IDX_W-1:0] crc_idx;
  logic [31:0]          cnt_upd;
  logic [PKT_LEN-1:0]   pkt_upd;
  logic [CRC_LEN-1:0]   crc_upd;
  logic [4:0]           lfsr_upd;
  logic                 len_bad;
  logic                 res_bad;
  logic                 pid_bad;

  // State after absorbing this cycle's bit; also used to judge a same-cycle EOP.
  always_comb begin
    recv     = (state == RECV_PID) || (state == RECV_DATA) || (state == RECV_CRC);
    accept   = recv && in_valid;
    end_now  = pkt_end && (recv || (state == WAIT_EOP) || (state == OVERRUN));
    fb       = in_bit ^ lfsr[4];
    pkt_idx  = PKT_IDX_W'(cnt);
    crc_idx  = CRC_IDX_W'(cnt - 32'(PKT_LEN));
    cnt_upd  = cnt;
    pkt_upd  = pkt_out;
    crc_upd  = crc_rcvd;
    lfsr_upd = lfsr;
    if (accept) begin
      cnt_upd = cnt + 32'd1;
      if (cnt < 32'(PKT_LEN)) begin
        pkt_upd = pkt_out | (PKT_LEN'(in_bit) << pkt_idx);
      end else begin
        crc_upd = crc_rcvd | (CRC_LEN'(in_bit) << crc_idx);
      end
      if (cnt >= 32'(PID_LEN)) begin
        lfsr_upd = {lfsr[3], lfsr[2], lfsr[1] ^ fb, lfsr[0], fb};
      end
    end
    len_bad = (state == OVERRUN) || (recv && (cnt_upd != 32'(TOTAL_LEN)));
    res_bad = (lfsr_upd != RESIDUAL);
    pid_bad = (cnt_upd < 32'(PID_LEN)) ||
              (pkt_upd[PID_LEN-1:PID_HALF] != ~pkt_upd[PID_HALF-1:0]);
  end

  // Receive FSM with registered result strobes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      lfsr      <= 5'b11111;
      cnt       <= 32'd0;
      pkt_out   <= '0;
      crc_rcvd  <= '0;
      pkt_valid <= 1'b0;
      crc_ok    <= 1'b0;
      crc_error <= 1'b0;
      pid_error <= 1'b0;
      len_error <= 1'b0;
      busy      <= 1'b0;
    end else begin
      pkt_valid <= 1'b0;
      crc_ok    <= 1'b0;
      crc_error <= 1'b0;
      pid_error <= 1'b0;
      len_error <= 1'b0;
      if (pkt_start) begin
        state    <= RECV_PID;
        lfsr     <= 5'b11111;
        cnt      <= 32'd0;
        pkt_out  <= '0;
        crc_rcvd <= '0;
        busy     <= 1'b1;
      end else begin
        cnt      <= cnt_upd;
        pkt_out  <= pkt_upd;
        crc_rcvd <= crc_upd;
        lfsr     <= lfsr_upd;
        if (end_now) begin
          state     <= DONE;
          busy      <= 1'b0;
          pkt_valid <= 1'b1;
          len_error <= len_bad;
          crc_error <= len_bad | res_bad;
          crc_ok    <= ~(len_bad | res_bad);
          pid_error <= pid_bad;
        end else begin
          case (state)
            RECV_PID, RECV_DATA, RECV_CRC: begin
              if (cnt_upd == 32'(TOTAL_LEN))      state <= WAIT_EOP;
              else if (cnt_upd >= 32'(PKT_LEN))   state <= RECV_CRC;
              else if (cnt_upd >= 32'(PID_LEN))   state <= RECV_DATA;
              else                                state <= RECV_PID;
            end
            WAIT_EOP: if (in_valid) state <= OVERRUN;
            DONE:     state <= IDLE;
            IDLE, OVERRUN: state <= state;
            default:  state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_crc5_check.sv
// Scoreboard bench for crc5_check: directed token vectors plus loopback from a
// CRC5 generator model.
module tb_crc5_check;

  logic        clock;
  logic        reset_n;
  logic        pkt_start;
  logic        in_bit;
  logic        in_valid;
  logic        pkt_end;
  logic [18:0] pkt_out;
  logic [4:0]  crc_rcvd;
  logic        pkt_valid;
  logic        crc_ok;
  logic        crc_error;
  logic        pid_error;
  logic        len_error;
  logic        busy;

  typedef struct packed {
    logic [18:0] pkt;
    logic [4:0]  crc;
    logic        ok;
    logic        cerr;
    logic        perr;
    logic        lerr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  crc5_check dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .pkt_start (pkt_start),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .pkt_end   (pkt_end),
    .pkt_out   (pkt_out),
    .crc_rcvd  (crc_rcvd),
    .pkt_valid (pkt_valid),
    .crc_ok    (crc_ok),
    .crc_error (crc_error),
    .pid_error (pid_error),
    .len_error (len_error),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor: compare every result strobe against the oldest expectation.
  always @(negedge clock) begin
    if (reset_n) begin
      if (pkt_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pkt_valid", 32'(pkt_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pkt_out",   32'(pkt_out),   32'(e.pkt));
          check("crc_rcvd",  32'(crc_rcvd),  32'(e.crc));
          check("crc_ok",    32'(crc_ok),    32'(e.ok));
          check("crc_error", 32'(crc_error), 32'(e.cerr));
          check("pid_error", 32'(pid_error), 32'(e.perr));
          check("len_error", 32'(len_error), 32'(e.lerr));
        end
      end else begin
        check("strobes_idle", 32'({crc_ok, crc_error, pid_error, len_error}), 32'd0);
      end
    end
  end

  function automatic logic [4:0] crc5_gen(input logic [10:0] d);
    logic [4:0] x;
    logic       f;
    logic [4:0] field;
    x = 5'b11111;
    for (int i = 0; i < 11; i++) begin
      f = d[i] ^ x[4];
      x = {x[3], x[2], x[1] ^ f, x[0], f};
    end
    x = ~x;
    for (int i = 0; i < 5; i++) field[i] = x[4-i];
    return field;
  endfunction

  task automatic expect_pkt(input logic [18:0] p, input logic [4:0] c,
                            input logic ok, input logic ce, input logic pe, input logic le);
    exp_t e;
    e.pkt = p; e.crc = c; e.ok = ok; e.cerr = ce; e.perr = pe; e.lerr = le;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic st, input logic b, input logic v, input logic en);
    @(negedge clock);
    pkt_start = st; in_bit = b; in_valid = v; pkt_end = en;
  endtask

  // The start cycle carries a valid-looking bit that must be ignored.
  task automatic send_start();
    drive(1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic send_end();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("latency", 32'(pkt_valid), 32'd1);
  endtask

  task automatic send_packet(input logic [31:0] s, input int n, input bit gaps, input bit end_on_last);
    send_start();
    for (int i = 0; i < n; i++) begin
      drive(1'b0, s[i], 1'b1, (end_on_last && i == n - 1) ? 1'b1 : 1'b0);
      if (gaps && (i + 1 == 5 || i + 1 == 12 || i + 1 == 20)) begin
        for (int g = 0; g < 3; g++) begin
          drive(1'b0, ~s[i], 1'b0, 1'b0);
          check("busy_in_gap", 32'(busy), 32'd1);
        end
      end
    end
    if (end_on_last) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check("latency_same_cycle", 32'(pkt_valid), 32'd1);
    end else begin
      send_end();
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
    if (exp_q.size() != 0) begin
      check("result_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  logic [31:0] good;
  logic [31:0] s;
  logic [3:0]  lo;
  logic [7:0]  pid;
  logic [10:0] data;
  logic [4:0]  c;

  initial begin
    reset_n = 1'b0; pkt_start = 1'b0; in_bit = 1'b0; in_valid = 1'b0; pkt_end = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_pkt_out",  32'(pkt_out),  32'd0);
    check("rst_crc_rcvd", 32'(crc_rcvd), 32'd0);
    check("rst_flags", 32'({pkt_valid, crc_ok, crc_error, pid_error, len_error, busy}), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // PID E1, zero addr/endp, CRC bits 0,1,0,0,0 in send order.
    good = {8'h00, 5'b00010, 11'd0, 8'hE1};

    expect_pkt(19'h000E1, 5'b00010, 1'b1, 1'b0, 1'b0, 1'b0);
    send_packet(good, 24, 1'b0, 1'b0);
    drain();

    expect_pkt(19'h000E1, 5'b00010, 1'b1, 1'b0, 1'b0, 1'b0);
    send_packet(good, 24, 1'b1, 1'b0);
    drain();

    s = good ^ 32'h0000_0800;
    expect_pkt(19'h008E1, 5'b00010, 1'b0, 1'b1, 1'b0, 1'b0);
    send_packet(s, 24, 1'b0, 1'b0);
    drain();

    s = {8'h00, 5'b00010, 11'd0, 8'hE0};
    expect_pkt(19'h000E0, 5'b00010, 1'b1, 1'b0, 1'b1, 1'b0);
    send_packet(s, 24, 1'b0, 1'b0);
    drain();

    expect_pkt(19'h000E1, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b1);
    send_packet(good, 20, 1'b0, 1'b0);
    drain();

    s = good | 32'h0100_0000;
    expect_pkt(19'h000E1, 5'b00010, 1'b0, 1'b1, 1'b0, 1'b1);
    send_packet(s, 25, 1'b0, 1'b0);
    drain();

    expect_pkt(19'h00001, 5'b00000, 1'b0, 1'b1, 1'b1, 1'b1);
    send_packet(good, 5, 1'b0, 1'b0);
    drain();

    expect_pkt(19'h000E1, 5'b00010, 1'b1, 1'b0, 1'b0, 1'b0);
    send_packet(good, 24, 1'b0, 1'b1);
    drain();

    // Abort after 10 bits, then a full packet: a single result.
    send_start();
    for (int i = 0; i < 10; i++) drive(1'b0, ~good[i], 1'b1, 1'b0);
    expect_pkt(19'h000E1, 5'b00010, 1'b1, 1'b0, 1'b0, 1'b0);
    send_packet(good, 24, 1'b0, 1'b0);
    drain();

    // Reset mid-packet.
    send_start();
    for (int i = 0; i < 10; i++) drive(1'b0, good[i], 1'b1, 1'b0);
    @(negedge clock);
    reset_n = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    check("midrst_pkt_out",  32'(pkt_out),  32'd0);
    check("midrst_crc_rcvd", 32'(crc_rcvd), 32'd0);
    check("midrst_flags", 32'({pkt_valid, crc_ok, crc_error, pid_error, len_error, busy}), 32'd0);
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_end_ignored", 32'(pkt_valid), 32'd0);
    drain();

    // Loopback from the generator model.
    for (int k = 0; k < 16; k++) begin
      lo   = 4'($urandom_range(0, 15));
      pid  = {~lo, lo};
      data = 11'($urandom);
      c    = crc5_gen(data);
      s    = {8'h00, c, data, pid};
      expect_pkt({data, pid}, c, 1'b1, 1'b0, 1'b0, 1'b0);
      send_packet(s, 24, (k % 4) == 1, (k % 4) == 3);
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc5_check.md
Name: crc5_check

Overview:
- Receive-side companion to the token-packet CRC5 generator.
- Accepts the de-stuffed serial bit stream from the bit unstuffer and assembles the 19-bit token (8-bit PID plus 11-bit addr/endp, LSB first).
- Runs the USB CRC5 over the 11 data bits plus the 5 received CRC bits, then checks the residual, the PID complement field and the packet length.
- Presents the result to the protocol handler as a one-cycle pkt_valid pulse.

Parameters:
PKT_LEN, 19, PID + addr/endp bits assembled into pkt_out
PID_LEN, 8, leading bits excluded from CRC
CRC_LEN, 5, trailing CRC bits
RESIDUAL, 5'b01100, good-packet remainder {x4,x3,x2,x1,x0}

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
pkt_start  input  1  pulse: SYNC seen; next valid bit is PID bit 0
in_bit  input  1  de-stuffed serial data bit
in_valid  input  1  in_bit is meaningful this cycle (low for removed stuff bits)
pkt_end  input  1  pulse: EOP detected
pkt_out  output  19  assembled packet; first received bit in bit 0
crc_rcvd  output  5  received CRC field; first CRC bit in bit 0
pkt_valid  output  1  one-cycle result strobe
crc_ok  output  1  qualified by pkt_valid: residual matched, length correct
crc_error  output  1  qualified by pkt_valid: residual mismatch or bad length
pid_error  output  1  qualified by pkt_valid: PID[7:4] != ~PID[3:0]
len_error  output  1  qualified by pkt_valid: bit count != 24 at EOP
busy  output  1  high from pkt_start until pkt_valid

Behaviour:
- Reset: all outputs 0; FSM in IDLE; LFSR = 5'b11111; bit counter = 0.
- LFSR update, applied only on accepted CRC-region bits:
  - x0 <= in_bit ^ x4; x1 <= x0; x2 <= x1 ^ (in_bit ^ x4); x3 <= x2; x4 <= x3.
- A bit is accepted only when in_valid = 1. Gaps of any length freeze all state.
- Counter: 32-bit; increments per accepted bit.
- FSM states:
  - IDLE: wait for pkt_start. On pkt_start: clear LFSR to 11111, counter to 0, pkt_out to 0, crc_rcvd to 0; busy = 1; go to RECV_PID.
  - RECV_PID: shift the accepted bit into pkt_out[count]. After the 8th bit, go to RECV_DATA. No CRC update.
  - RECV_DATA: store into pkt_out[count] and update LFSR. After bit 19, go to RECV_CRC.
  - RECV_CRC: store into crc_rcvd[count-19] and update LFSR. After bit 24, go to WAIT_EOP.
  - WAIT_EOP:
    - pkt_end: go to DONE.
    - in_valid without pkt_end: go to OVERRUN (bit discarded).
  - OVERRUN: ignore bits; on pkt_end go to DONE with len_error = 1.
  - DONE (one cycle):
    - pkt_valid = 1, busy = 0.
    - len_error as latched.
    - crc_error = len_error | (LFSR != RESIDUAL).
    - crc_ok = ~crc_error.
    - pid_error evaluated on pkt_out[7:0].
    - Next state IDLE.
- Early EOP: pkt_end in RECV_PID, RECV_DATA or RECV_CRC goes to DONE with len_error = 1 and crc_error = 1.
  - pid_error is evaluated only if at least 8 bits were received; otherwise it is 1.
- Latency: pkt_valid is asserted exactly 1 cycle after the cycle pkt_end is sampled.
- Simultaneous pkt_end and in_valid in a RECV state: the bit is accepted first, then the end is evaluated with the updated count.
  - On the 24th bit this yields a good packet.
- pkt_start in any non-IDLE state aborts the current packet: no pkt_valid, restart as from IDLE.
  - The in_bit/in_valid in the pkt_start cycle is ignored.
- pkt_out, crc_rcvd and the status flags hold their values after DONE until the next pkt_start.
  - pkt_valid, crc_ok, crc_error, pid_error and len_error are strobes. crc_ok, crc_error, pid_error and len_error are 0 whenever pkt_valid = 0.
- pkt_end in IDLE is ignored.
- Reset mid-packet: immediate return to the reset state; no pkt_valid.

Test Plan:
1. Good token, contiguous. pkt_start, then 24 bits with in_valid = 1: PID 8'hE1 sent LSB first, 11 zero data bits, CRC bits 0,1,0,0,0. Then pkt_end.
   -> 1 cycle later pkt_valid = 1, crc_ok = 1, crc_error = 0, pid_error = 0, len_error = 0, pkt_out = 19'h000E1, crc_rcvd = 5'b00010.
2. Same packet with in_valid deasserted for 3 cycles after bits 5, 12 and 20.
   -> identical result; busy stays high throughout.
3. Case 1 with data bit 3 flipped.
   -> pkt_valid = 1, crc_error = 1, crc_ok = 0, len_error = 0.
4. PID 8'hE0, valid CRC.
   -> pid_error = 1, crc_ok = 1.
5. Length errors:
   - pkt_end after 20 bits -> pkt_valid, len_error = 1, crc_error = 1.
   - 25 bits then pkt_end -> len_error = 1, crc_error = 1.
6. Abort and reset:
   - pkt_start after 10 bits, then a full good packet -> exactly one pkt_valid, with crc_ok = 1.
   - reset_n low mid-packet -> all outputs 0 and no pkt_valid.
   - Loopback from the CRC5 generator with 16 random 19-bit packets -> all crc_ok = 1 and pkt_out matches the source.
